// File: rtl/rx_fifo_ctrl_pkg.sv
// Shared types and default parameters for the receive FIFO drain sequencer.
package rx_fifo_ctrl_pkg;

  // Default parameterisation of rx_fifo_ctrl.
  localparam int DATA_W_DEF  = 8;
  localparam int LEN_W_DEF   = 7;
  localparam int MAX_LEN_DEF = 127;
  localparam int TIMEOUT_DEF = 16;

  // Sequencer states. The encodings are fixed so they stay stable across revisions.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    PUSH   = 2'd3
  } state_t;

  // Frame parsing phase: waiting for a header byte, or inside a payload.
  typedef enum logic {
    HDR = 1'b0,
    PAY = 1'b1
  } phase_t;

endpackage

// File: rtl/rx_fifo_ctrl.sv
// APB-master sequencer that drains fifo_rx one byte per transfer, parses the
// first byte of each frame as the PHR length and streams the payload to the MAC.
module rx_fifo_ctrl
  import rx_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mem_state,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata,
  output logic [DATA_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              frame_start,
  output logic              frame_done,
  output logic [LEN_W-1:0]  frame_len,
  output logic              err_slv,
  output logic              err_tout,
  output logic              err_len,
  output logic              busy
);

  localparam int              TW         = $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TOUT_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   WAIT_ONE   = TW'(1);
  localparam logic [LEN_W:0]  MAX_LEN_C  = (LEN_W + 1)'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO  = LEN_W'(0);

  // Architectural state
  state_t             state_r;
  phase_t             phase_r;
  logic [LEN_W-1:0]   rem_r;
  logic [TW-1:0]      wait_r;
  logic [LEN_W-1:0]   frame_len_r;
  logic [DATA_W-1:0]  byte_data_r;

  // Registered outputs
  logic               psel_r;
  logic               penable_r;
  logic               byte_valid_r;
  logic               busy_r;
  logic               frame_start_r;
  logic               err_slv_r;
  logic               err_tout_r;
  logic               err_len_r;

  // Next-state values
  state_t             state_nxt_s;
  phase_t             phase_nxt_s;
  logic [LEN_W-1:0]   rem_nxt_s;
  logic [TW-1:0]      wait_nxt_s;
  logic [LEN_W-1:0]   frame_len_nxt_s;
  logic [DATA_W-1:0]  byte_data_nxt_s;
  logic               start_s;
  logic               slv_s;
  logic               tout_s;
  logic               len_err_s;

  // Header decode: bit 7 of the header byte is not part of the length.
  logic [LEN_W-1:0]   hdr_len_s;
  logic               hdr_legal_s;

  assign hdr_len_s   = prdata[LEN_W-1:0];
  assign hdr_legal_s = (hdr_len_s != LEN_ZERO) && ({1'b0, hdr_len_s} <= MAX_LEN_C);

  // Next-state and event decode for the transfer sequencer and frame parser.
  always_comb begin
    state_nxt_s     = state_r;
    phase_nxt_s     = phase_r;
    rem_nxt_s       = rem_r;
    wait_nxt_s      = wait_r;
    frame_len_nxt_s = frame_len_r;
    byte_data_nxt_s = byte_data_r;
    start_s         = 1'b0;
    slv_s           = 1'b0;
    tout_s          = 1'b0;
    len_err_s       = 1'b0;

    case (state_r)
      IDLE: begin
        // mem_state is only looked at here, so every transfer is preceded by IDLE.
        if (en && mem_state) begin
          state_nxt_s = SETUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      SETUP: begin
        state_nxt_s = ACCESS;
        wait_nxt_s  = {TW{1'b0}};
      end

      ACCESS: begin
        if (pready) begin
          wait_nxt_s = {TW{1'b0}};
          if (pslverr) begin
            slv_s       = 1'b1;
            phase_nxt_s = HDR;
            rem_nxt_s   = LEN_ZERO;
            state_nxt_s = IDLE;
          end else if (phase_r == HDR) begin
            state_nxt_s = IDLE;
            if (hdr_legal_s) begin
              start_s         = 1'b1;
              frame_len_nxt_s = hdr_len_s;
              rem_nxt_s       = hdr_len_s;
              phase_nxt_s     = PAY;
            end else begin
              len_err_s = 1'b1;
            end
          end else begin
            byte_data_nxt_s = prdata;
            state_nxt_s     = PUSH;
          end
        end else if (wait_r == TOUT_LAST) begin
          // The slave never answered: abandon the frame and resynchronise on a header.
          tout_s      = 1'b1;
          wait_nxt_s  = {TW{1'b0}};
          phase_nxt_s = HDR;
          rem_nxt_s   = LEN_ZERO;
          state_nxt_s = IDLE;
        end else begin
          wait_nxt_s = wait_r + WAIT_ONE;
        end
      end

      PUSH: begin
        // byte_valid is asserted throughout PUSH, so byte_ready alone marks the accept.
        if (byte_ready) begin
          state_nxt_s = IDLE;
          if (rem_r != LEN_ZERO) begin
            rem_nxt_s = rem_r - LEN_ONE;
          end else begin
            rem_nxt_s = LEN_ZERO;
          end
          if (rem_r <= LEN_ONE) begin
            phase_nxt_s = HDR;
          end else begin
            phase_nxt_s = PAY;
          end
        end else begin
          state_nxt_s = PUSH;
        end
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers; outputs are derived from next-state so they align with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      phase_r       <= HDR;
      rem_r         <= LEN_ZERO;
      wait_r        <= {TW{1'b0}};
      frame_len_r   <= LEN_ZERO;
      byte_data_r   <= {DATA_W{1'b0}};
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      byte_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
      frame_start_r <= 1'b0;
      err_slv_r     <= 1'b0;
      err_tout_r    <= 1'b0;
      err_len_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      phase_r       <= phase_nxt_s;
      rem_r         <= rem_nxt_s;
      wait_r        <= wait_nxt_s;
      frame_len_r   <= frame_len_nxt_s;
      byte_data_r   <= byte_data_nxt_s;
      psel_r        <= (state_nxt_s == SETUP) || (state_nxt_s == ACCESS);
      penable_r     <= (state_nxt_s == ACCESS);
      byte_valid_r  <= (state_nxt_s == PUSH);
      busy_r        <= (state_nxt_s != IDLE) || (phase_nxt_s == PAY);
      frame_start_r <= start_s;
      err_slv_r     <= slv_s;
      err_tout_r    <= tout_s;
      err_len_r     <= len_err_s;
    end
  end

  assign psel        = psel_r;
  assign penable     = penable_r;
  assign pwrite      = 1'b0;
  assign byte_data   = byte_data_r;
  assign byte_valid  = byte_valid_r;
  assign frame_start = frame_start_r;
  assign frame_len   = frame_len_r;
  assign err_slv     = err_slv_r;
  assign err_tout    = err_tout_r;
  assign err_len     = err_len_r;
  assign busy        = busy_r;

  // frame_done must coincide with the accepting handshake, so it follows byte_ready directly.
  assign frame_done  = byte_valid_r & byte_ready & (rem_r == LEN_ONE);

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Self-checking bench for rx_fifo_ctrl: an APB slave FIFO model, a MAC sink and
// a transaction-level frame parser predicting the event stream the DUT must emit.
module tb_rx_fifo_ctrl;

  localparam int TIMEOUT = 16;

  localparam int EV_START = 0;
  localparam int EV_BYTE  = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_SLV   = 3;
  localparam int EV_TOUT  = 4;
  localparam int EV_LEN   = 5;

  typedef struct packed {
    logic [7:0] d;
    logic       err;
    logic       tout;
  } ent_t;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       en;
  logic       mem_state;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic       pready;
  logic       pslverr;
  logic [7:0] prdata;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       frame_start;
  logic       frame_done;
  logic [6:0] frame_len;
  logic       err_slv;
  logic       err_tout;
  logic       err_len;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  ev_t  exp_q[$];
  bit   stalling = 1'b0;
  int   acc_cnt = 0;
  int   cur_delay = 0;
  int   max_delay = 0;
  int   rdy_pct = 100;
  bit   en_rand = 1'b0;
  int   bp_left = 0;
  logic [7:0] bp_target = 8'h00;
  bit   prev_setup = 1'b0;

  // Reference parser state: inside a payload or not, and bytes still to come.
  bit   m_pay = 1'b0;
  int   m_rem = 0;

  // Observed statistics
  int   n_start, n_done, n_beats, n_slv, n_tout, n_len;
  int   last_start_len, last_done_data;
  int   last_beat;

  rx_fifo_ctrl dut (
    .clk(clk), .reset(reset), .en(en), .mem_state(mem_state),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .pready(pready), .pslverr(pslverr), .prdata(prdata),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .frame_start(frame_start), .frame_done(frame_done), .frame_len(frame_len),
    .err_slv(err_slv), .err_tout(err_tout), .err_len(err_len), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic exp_push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Frame rules applied to every byte the slave hands out.
  task automatic model_read(input ent_t e);
    int len;
    if (e.err) begin
      exp_push(EV_SLV, 0);
      m_pay = 1'b0;
      m_rem = 0;
    end else if (!m_pay) begin
      len = int'(e.d[6:0]);
      if (len == 0 || len > 127) begin
        exp_push(EV_LEN, 0);
      end else begin
        exp_push(EV_START, len);
        m_pay = 1'b1;
        m_rem = len;
      end
    end else begin
      exp_push(EV_BYTE, int'(e.d));
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        exp_push(EV_DONE, 0);
        m_pay = 1'b0;
      end
    end
  endtask

  task automatic sb_obs(input int kind, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind=%0d val=%0h, required no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.val !== val) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d val=%0h, required kind=%0d val=%0h", kind, val, e.kind, e.val);
      end
    end
    case (kind)
      EV_START: begin n_start++; last_start_len = val; end
      EV_BYTE:  begin n_beats++; last_beat = val; end
      EV_DONE:  begin n_done++; last_done_data = last_beat; end
      EV_SLV:   n_slv++;
      EV_TOUT:  n_tout++;
      EV_LEN:   n_len++;
      default:  ;
    endcase
  endtask

  task automatic push_b(input logic [7:0] d, input bit e, input bit t);
    ent_t x;
    x.d    = d;
    x.err  = e;
    x.tout = t;
    q.push_back(x);
  endtask

  // Input drivers (slave + sink) at the falling edge, then the monitor 1 time unit later.
  initial begin
    forever begin
      @(negedge clk);
      if (byte_valid && (bp_left > 0) && (byte_data == bp_target)) begin
        byte_ready = 1'b0;
        bp_left--;
      end else if (rdy_pct >= 100) begin
        byte_ready = 1'b1;
      end else begin
        byte_ready = ($urandom_range(0, 99) < rdy_pct);
      end
      if (en_rand) en = ($urandom_range(0, 7) != 0);

      if (psel && penable && !reset && q.size() > 0) begin
        if (acc_cnt == 0 && q[0].tout && !stalling) begin
          stalling = 1'b1;
          exp_push(EV_TOUT, 0);
          m_pay = 1'b0;
          m_rem = 0;
        end
        if (!stalling && acc_cnt >= cur_delay) begin
          pready  = 1'b1;
          prdata  = q[0].d;
          pslverr = q[0].err;
          model_read(q[0]);
          void'(q.pop_front());
        end else begin
          pready  = 1'b0;
          pslverr = 1'b0;
        end
        acc_cnt++;
      end else begin
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = 8'($urandom);
        acc_cnt   = 0;
        cur_delay = (max_delay > 0) ? $urandom_range(0, max_delay) : 0;
        if (stalling && !(psel && penable)) begin
          if (q.size() > 0) q[0].tout = 1'b0;
          stalling = 1'b0;
        end
      end
      mem_state = (q.size() > 0);

      #1;
      if (!reset) begin
        checks++;
        if (pwrite !== 1'b0) begin
          errors++;
          $display("FAIL pwrite: got %b, required 0", pwrite);
        end
        if (prev_setup) begin
          checks++;
          if (!(psel === 1'b1 && penable === 1'b1)) begin
            errors++;
            $display("FAIL setup_then_access: got psel=%b penable=%b, required 1 1", psel, penable);
          end
        end
        prev_setup = (psel === 1'b1) && (penable === 1'b0);
        if (byte_valid === 1'b1 && psel === 1'b1) begin
          checks++;
          errors++;
          $display("FAIL apb_during_push: got psel=1 with byte_valid=1, required psel=0");
        end
        if (frame_start) sb_obs(EV_START, int'(frame_len));
        if (err_len)     sb_obs(EV_LEN, 0);
        if (err_slv)     sb_obs(EV_SLV, 0);
        if (err_tout)    sb_obs(EV_TOUT, 0);
        if (byte_valid && byte_ready) sb_obs(EV_BYTE, int'(byte_data));
        if (frame_done)  sb_obs(EV_DONE, 0);
      end else begin
        prev_setup = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #3;
    reset = 1'b1;
    en_rand = 1'b0;
    en = 1'b1;
    q.delete();
    exp_q.delete();
    stalling = 1'b0;
    m_pay = 1'b0;
    m_rem = 0;
    bp_left = 0;
    rdy_pct = 100;
    max_delay = 0;
    n_start = 0; n_done = 0; n_beats = 0; n_slv = 0; n_tout = 0; n_len = 0;
    last_start_len = -1; last_done_data = -1; last_beat = -1;
    repeat (2) @(negedge clk);
    #3;
    reset = 1'b0;
  endtask

  // Waits until the FIFO is empty, the bus is quiet and every predicted event was seen.
  task automatic wait_drain(input int budget, input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
      if (q.size() == 0 && !psel && !byte_valid && exp_q.size() == 0 && !stalling) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending events %0d fifo bytes after %0d cycles, required 0 0", name, exp_q.size(), q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if ({psel, penable, pwrite, byte_valid, frame_start, frame_done, err_slv, err_tout, err_len, busy} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 0000000000",
               {psel, penable, pwrite, byte_valid, frame_start, frame_done, err_slv, err_tout, err_len, busy});
    end
    checks++;
    if (frame_len !== 7'd0 || byte_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: got frame_len=%0d byte_data=%0h, required 0 0", frame_len, byte_data);
    end
    do_reset();
    repeat (5) @(negedge clk);
    #2;
    checks++;
    if (psel !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_empty: got psel=%b busy=%b, required 0 0", psel, busy);
    end
  endtask

  task automatic test_basic_frame();
    do_reset();
    push_b(8'h03, 1'b0, 1'b0);
    push_b(8'hA1, 1'b0, 1'b0);
    push_b(8'hB2, 1'b0, 1'b0);
    push_b(8'hC3, 1'b0, 1'b0);
    wait_drain(500, "basic");
    checks++;
    if (n_start !== 1 || last_start_len !== 3) begin
      errors++;
      $display("FAIL basic_start: got count=%0d len=%0d, required 1 3", n_start, last_start_len);
    end
    checks++;
    if (n_beats !== 3 || n_done !== 1 || last_done_data !== 32'hC3) begin
      errors++;
      $display("FAIL basic_beats: got beats=%0d done=%0d last=%0h, required 3 1 c3", n_beats, n_done, last_done_data);
    end
    checks++;
    if (frame_len !== 7'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: got frame_len=%0d busy=%b, required 3 0", frame_len, busy);
    end
  endtask

  task automatic test_latency();
    int n;
    do_reset();
    push_b(8'h01, 1'b0, 1'b0);
    wait_drain(200, "lat_hdr");
    checks++;
    if (busy !== 1'b1 || psel !== 1'b0) begin
      errors++;
      $display("FAIL busy_mid_frame: got busy=%b psel=%b, required 1 0", busy, psel);
    end
    push_b(8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    n = 0;
    while (!byte_valid && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL latency: got %0d cycles, required 3", n);
    end
    wait_drain(200, "lat");
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    bp_target = 8'hB2;
    bp_left = 5;
    push_b(8'h03, 1'b0, 1'b0);
    push_b(8'hA1, 1'b0, 1'b0);
    push_b(8'hB2, 1'b0, 1'b0);
    push_b(8'hC3, 1'b0, 1'b0);
    while (!(byte_valid && byte_data == 8'hB2) && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (byte_valid !== 1'b1 || byte_data !== 8'hB2 || psel !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%0h psel=%b, required 1 b2 0", i, byte_valid, byte_data, psel);
      end
      @(negedge clk);
      #2;
    end
    wait_drain(500, "bp");
    checks++;
    if (n_beats !== 3 || n_done !== 1 || last_done_data !== 32'hC3) begin
      errors++;
      $display("FAIL bp_frame: got beats=%0d done=%0d last=%0h, required 3 1 c3", n_beats, n_done, last_done_data);
    end
  endtask

  task automatic test_slverr();
    do_reset();
    push_b(8'h03, 1'b0, 1'b0);
    push_b(8'hA1, 1'b0, 1'b0);
    push_b(8'hB2, 1'b1, 1'b0);
    push_b(8'h01, 1'b0, 1'b0);
    push_b(8'h55, 1'b0, 1'b0);
    wait_drain(500, "slv");
    checks++;
    if (n_slv !== 1 || n_start !== 2 || last_start_len !== 1) begin
      errors++;
      $display("FAIL slverr_recover: got slv=%0d starts=%0d len=%0d, required 1 2 1", n_slv, n_start, last_start_len);
    end
    checks++;
    if (n_done !== 1 || last_done_data !== 32'h55 || n_beats !== 2) begin
      errors++;
      $display("FAIL slverr_frames: got done=%0d last=%0h beats=%0d, required 1 55 2", n_done, last_done_data, n_beats);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int acc = 0;
    do_reset();
    push_b(8'h02, 1'b0, 1'b0);
    wait_drain(200, "tout_hdr");
    push_b(8'h01, 1'b0, 1'b1);
    push_b(8'h77, 1'b0, 1'b0);
    while (!(psel && penable) && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    while (psel && penable && acc < 100) begin
      acc++;
      @(negedge clk);
      #2;
    end
    checks++;
    if (acc !== TIMEOUT) begin
      errors++;
      $display("FAIL tout_cycles: got %0d access cycles, required %0d", acc, TIMEOUT);
    end
    checks++;
    if (err_tout !== 1'b1 || psel !== 1'b0 || penable !== 1'b0) begin
      errors++;
      $display("FAIL tout_pulse: got err_tout=%b psel=%b penable=%b, required 1 0 0", err_tout, psel, penable);
    end
    wait_drain(500, "tout");
    checks++;
    if (n_tout !== 1 || n_start !== 2 || n_done !== 1 || last_done_data !== 32'h77) begin
      errors++;
      $display("FAIL tout_recover: got tout=%0d starts=%0d done=%0d last=%0h, required 1 2 1 77",
               n_tout, n_start, n_done, last_done_data);
    end
  endtask

  task automatic test_len_and_en();
    do_reset();
    en = 1'b0;
    push_b(8'h00, 1'b0, 1'b0);
    push_b(8'h80, 1'b0, 1'b0);
    push_b(8'h82, 1'b0, 1'b0);
    push_b(8'h11, 1'b0, 1'b0);
    push_b(8'h22, 1'b0, 1'b0);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        #2;
        if (psel) seen++;
      end
      checks++;
      if (seen !== 0) begin
        errors++;
        $display("FAIL en_low: got %0d psel cycles, required 0", seen);
      end
    end
    en = 1'b1;
    wait_drain(500, "len");
    checks++;
    if (n_len !== 2 || n_start !== 1 || frame_len !== 7'd2) begin
      errors++;
      $display("FAIL len_check: got err_len=%0d starts=%0d frame_len=%0d, required 2 1 2", n_len, n_start, frame_len);
    end
    checks++;
    if (n_done !== 1 || last_done_data !== 32'h22) begin
      errors++;
      $display("FAIL len_frame: got done=%0d last=%0h, required 1 22", n_done, last_done_data);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    push_b(8'h01, 1'b0, 1'b1);
    while (!(psel && penable) && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    repeat (3) @(negedge clk);
    #3;
    reset = 1'b1;
    @(negedge clk);
    #2;
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || byte_valid !== 1'b0 || busy !== 1'b0 || err_tout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got psel=%b penable=%b valid=%b busy=%b tout=%b, required 0 0 0 0 0",
               psel, penable, byte_valid, busy, err_tout);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [7:0] h;
    int len;
    do_reset();
    rdy_pct = 70;
    max_delay = 3;
    en_rand = 1'b1;
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        h = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h00;
        push_b(h, 1'b0, 1'b0);
      end else begin
        len = $urandom_range(1, 5);
        h = 8'(len);
        h[7] = 1'($urandom_range(0, 1));
        push_b(h, ($urandom_range(0, 99) < 4), 1'b0);
        for (int b = 0; b < len; b++) begin
          bit e;
          bit t;
          e = ($urandom_range(0, 99) < 4);
          t = !e && ($urandom_range(0, 99) < 3);
          push_b(8'($urandom), e, t);
        end
      end
    end
    wait_drain(30000, "random");
    en_rand = 1'b0;
    en = 1'b1;
    checks++;
    if (n_start + n_len + n_slv == 0) begin
      errors++;
      $display("FAIL random_activity: got 0 frame events, required >0");
    end
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b1;
    mem_state = 1'b0;
    pready = 1'b0;
    pslverr = 1'b0;
    prdata = 8'h00;
    byte_ready = 1'b0;
    n_start = 0; n_done = 0; n_beats = 0; n_slv = 0; n_tout = 0; n_len = 0;
    last_start_len = -1; last_done_data = -1; last_beat = -1;
    test_reset();
    test_basic_frame();
    test_latency();
    test_backpressure();
    test_slverr();
    test_timeout();
    test_len_and_en();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
